// File: rtl/processor_mc.sv
// processor_mc: parametrised multi-cycle core with a loadable instruction memory.
// Each instruction takes a FETCH cycle and an EXEC cycle. IN stalls in WAIT_IN
// until data is offered. HALT and illegal opcodes park the core until reset.
module processor_mc #(
   parameter int DATA_W  = 8,
   parameter int REG_AW  = 2,
   parameter int PC_W    = 5,
   parameter int INSTR_W = 4 + 2*REG_AW + DATA_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DATA_W-1:0]  IN,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [DATA_W-1:0]  OUT,
   output logic               out_valid,
   input  logic               prog_we,
   input  logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic               halted,
   output logic               error,
   output logic [PC_W-1:0]    pc_dbg
);

   localparam int NREG  = 2**REG_AW;
   localparam int DEPTH = 2**PC_W;
   localparam logic [PC_W-1:0] PC_ONE = 1;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LDI  = 4'd1;
   localparam logic [3:0] OP_MOV  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_NOT  = 4'd7;
   localparam logic [3:0] OP_JMP  = 4'd8;
   localparam logic [3:0] OP_JZ   = 4'd9;
   localparam logic [3:0] OP_JN   = 4'd10;
   localparam logic [3:0] OP_IN   = 4'd11;
   localparam logic [3:0] OP_OUT  = 4'd12;
   localparam logic [3:0] OP_HALT = 4'd13;
   localparam logic [3:0] OP_JC   = 4'd14;
   localparam logic [3:0] OP_ILL  = 4'd15;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT_IN, S_HALT} state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INSTR_W-1:0]  instr_q;
   logic [INSTR_W-1:0]  imem [DEPTH];
   logic [DATA_W-1:0]   rf_q [NREG];
   logic                z_q, z_d, n_q, n_d, c_q, c_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic                out_valid_q, out_valid_d;
   logic                error_q, error_d;

   logic                rf_we;
   logic [DATA_W-1:0]   rf_wdata;
   logic                flag_upd;

   // Instruction field decode, MSB first: op, ra, rb, imm.
   logic [3:0]          op;
   logic [REG_AW-1:0]   ra, rb;
   logic [DATA_W-1:0]   imm;
   logic [DATA_W-1:0]   opa, opb;
   logic [DATA_W:0]     sum_w, diff_w;

   assign op   = instr_q[INSTR_W-1 -: 4];
   assign ra   = instr_q[INSTR_W-5 -: REG_AW];
   assign rb   = instr_q[INSTR_W-5-REG_AW -: REG_AW];
   assign imm  = instr_q[DATA_W-1:0];
   assign opa  = rf_q[ra];
   assign opb  = rf_q[rb];
   // The extra top bit is the carry for ADD and the borrow for SUB.
   assign sum_w  = {1'b0, opa} + {1'b0, opb};
   assign diff_w = {1'b0, opa} - {1'b0, opb};

   assign OUT       = out_q;
   assign out_valid = out_valid_q;
   assign halted    = (state_q == S_HALT);
   assign error     = error_q;
   assign pc_dbg    = pc_q;

   // Next-state, datapath control and handshake for the FETCH/EXEC/WAIT_IN/HALT machine.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      z_d         = z_q;
      n_d         = n_q;
      c_d         = c_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      error_d     = error_q;
      rf_we       = 1'b0;
      rf_wdata    = '0;
      flag_upd    = 1'b0;
      in_ready    = 1'b0;
      case (state_q)
         S_FETCH: begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (op)
               OP_LDI: begin rf_we = 1'b1; rf_wdata = imm; end
               OP_MOV: begin rf_we = 1'b1; rf_wdata = opb; end
               OP_ADD: begin
                  rf_we = 1'b1; rf_wdata = sum_w[DATA_W-1:0];
                  c_d = sum_w[DATA_W]; flag_upd = 1'b1;
               end
               OP_SUB: begin
                  rf_we = 1'b1; rf_wdata = diff_w[DATA_W-1:0];
                  c_d = diff_w[DATA_W]; flag_upd = 1'b1;
               end
               OP_AND: begin rf_we = 1'b1; rf_wdata = opa & opb; c_d = 1'b0; flag_upd = 1'b1; end
               OP_OR:  begin rf_we = 1'b1; rf_wdata = opa | opb; c_d = 1'b0; flag_upd = 1'b1; end
               OP_NOT: begin rf_we = 1'b1; rf_wdata = ~opb;      c_d = 1'b0; flag_upd = 1'b1; end
               OP_JMP: pc_d = imm[PC_W-1:0];
               OP_JZ:  if (z_q) pc_d = imm[PC_W-1:0];
               OP_JN:  if (n_q) pc_d = imm[PC_W-1:0];
               OP_JC:  if (c_q) pc_d = imm[PC_W-1:0];
               OP_IN: begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     rf_we = 1'b1; rf_wdata = IN;
                  end else begin
                     state_d = S_WAIT_IN;
                  end
               end
               OP_OUT: begin out_d = opa; out_valid_d = 1'b1; end
               OP_HALT: state_d = S_HALT;
               OP_ILL: begin error_d = 1'b1; state_d = S_HALT; end
               default: ;
            endcase
            if (flag_upd) begin
               z_d = (rf_wdata == '0);
               n_d = rf_wdata[DATA_W-1];
            end
         end
         S_WAIT_IN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               rf_we   = 1'b1;
               rf_wdata = IN;
               state_d = S_FETCH;
            end
         end
         default: ;
      endcase
   end

   // Control and flag state; reset returns the core to FETCH at pc 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_FETCH;
         pc_q        <= '0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         c_q         <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         z_q         <= z_d;
         n_q         <= n_d;
         c_q         <= c_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         error_q     <= error_d;
      end
   end

   // Register file; the write lands at the end of EXEC/WAIT_IN so the next EXEC sees it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[ra] <= rf_wdata;
      end
   end

   // Instruction memory write port; untouched by reset so a program survives it.
   always_ff @(posedge clk) begin
      if (prog_we) imem[prog_addr] <= prog_data;
   end

   // Synchronous fetch; reading in the same edge as a write returns the old word.
   always_ff @(posedge clk) begin
      if (state_q == S_FETCH) instr_q <= imem[pc_q];
   end

endmodule
